exec_mem_slice: RTL and testbench

//  Single-cycle decode/execute/memory slice of the RV32I core.
//  - Decodes one instruction into control, then runs the ALU and the byte-addressed data memory.
//  - Produces branch/jump select, load data and the register write-back value.
//  - Register file, immediate generator and PC register stay outside; this slice sits between them.

---
 rtl/exec_mem_slice.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_exec_mem_slice.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_slice.sv
// Single-cycle RV32I decode/execute/memory slice: decodes one instruction, runs the ALU,
// accesses a little-endian byte-addressed data memory and forms the write-back value.
module exec_mem_slice #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MEM_ABITS = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic [WIDTH-1:0]  rd1,
  input  logic [WIDTH-1:0]  rd2,
  input  logic [WIDTH-1:0]  pc,
  input  logic [WIDTH-1:0]  imm,
  output logic [2:0]        imm_src,
  output logic              reg_write,
  output logic [4:0]        rd_addr,
  output logic [WIDTH-1:0]  alu_result,
  output logic              eq,
  output logic [1:0]        pc_src,
  output logic [WIDTH-1:0]  read_data,
  output logic [WIDTH-1:0]  wb_data
);

  localparam int unsigned SHAMT_W   = $clog2(WIDTH);
  localparam int unsigned MEM_BYTES = 2 ** MEM_ABITS;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;
  localparam logic [2:0] BR_BLTU = 3'b101;
  localparam logic [2:0] BR_BGEU = 3'b110;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JAL  = 2'b10;
  localparam logic [1:0] JMP_JALR = 2'b11;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_PASS = 4'b1010,
    ALU_BLT  = 4'b1011,
    ALU_BGE  = 4'b1100,
    ALU_BLTU = 4'b1101,
    ALU_BGEU = 4'b1110
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    MEM_LW   = 4'b0000,
    MEM_LH   = 4'b0001,
    MEM_LHU  = 4'b0010,
    MEM_LB   = 4'b0011,
    MEM_LBU  = 4'b0100,
    MEM_SW   = 4'b0101,
    MEM_SH   = 4'b0110,
    MEM_SB   = 4'b0111,
    MEM_NONE = 4'b1000
  } mem_mode_e;

  typedef struct packed {
    logic [2:0] imm_src;
    logic       reg_write;
    logic       a_pc;
    logic       b_imm;
    alu_ctrl_e  alu_ctrl;
    logic [2:0] branch;
    logic [1:0] jump;
    mem_mode_e  mem_mode;
    logic       wb_link;
    logic       wb_mem;
  } ctrl_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  ctrl_t      ctrl;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign alt     = instr[30];
  assign rd_addr = instr[11:7];

  // Remaining encoding bits are handled by the external immediate generator.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15]};

  // Instruction decode; unknown opcodes fall through as a NOP.
  always_comb begin
    ctrl           = '0;
    ctrl.imm_src   = IMM_I;
    ctrl.alu_ctrl  = ALU_ADD;
    ctrl.branch    = BR_NONE;
    ctrl.jump      = JMP_NONE;
    ctrl.mem_mode  = MEM_NONE;
    unique case (opcode)
      OPC_LUI: begin
        ctrl.imm_src   = IMM_U;
        ctrl.reg_write = 1'b1;
        ctrl.b_imm     = 1'b1;
        ctrl.alu_ctrl  = ALU_PASS;
      end
      OPC_AUIPC: begin
        ctrl.imm_src   = IMM_U;
        ctrl.reg_write = 1'b1;
        ctrl.a_pc      = 1'b1;
        ctrl.b_imm     = 1'b1;
      end
      OPC_JAL: begin
        ctrl.imm_src   = IMM_J;
        ctrl.reg_write = 1'b1;
        ctrl.b_imm     = 1'b1;
        ctrl.jump      = JMP_JAL;
        ctrl.wb_link   = 1'b1;
      end
      OPC_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.b_imm     = 1'b1;
        ctrl.jump      = JMP_JALR;
        ctrl.wb_link   = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.imm_src  = IMM_B;
        ctrl.alu_ctrl = ALU_SUB;
        case (funct3)
          3'b000:  ctrl.branch = BR_BEQ;
          3'b001:  ctrl.branch = BR_BNE;
          3'b100:  begin ctrl.branch = BR_BLT;  ctrl.alu_ctrl = ALU_BLT;  end
          3'b101:  begin ctrl.branch = BR_BGE;  ctrl.alu_ctrl = ALU_BGE;  end
          3'b110:  begin ctrl.branch = BR_BLTU; ctrl.alu_ctrl = ALU_BLTU; end
          3'b111:  begin ctrl.branch = BR_BGEU; ctrl.alu_ctrl = ALU_BGEU; end
          default: ctrl.branch = BR_NONE;
        endcase
      end
      OPC_LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.b_imm     = 1'b1;
        ctrl.wb_mem    = 1'b1;
        case (funct3)
          3'b000:  ctrl.mem_mode = MEM_LB;
          3'b001:  ctrl.mem_mode = MEM_LH;
          3'b010:  ctrl.mem_mode = MEM_LW;
          3'b100:  ctrl.mem_mode = MEM_LBU;
          3'b101:  ctrl.mem_mode = MEM_LHU;
          default: ctrl.mem_mode = MEM_NONE;
        endcase
      end
      OPC_STORE: begin
        ctrl.imm_src = IMM_S;
        ctrl.b_imm   = 1'b1;
        case (funct3)
          3'b000:  ctrl.mem_mode = MEM_SB;
          3'b001:  ctrl.mem_mode = MEM_SH;
          3'b010:  ctrl.mem_mode = MEM_SW;
          default: ctrl.mem_mode = MEM_NONE;
        endcase
      end
      OPC_OPIMM, OPC_OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.b_imm     = (opcode == OPC_OPIMM);
        case (funct3)
          // Only register-register ADD uses bit 30 to select SUB.
          3'b000:  ctrl.alu_ctrl = (alt && opcode == OPC_OP) ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl.alu_ctrl = ALU_SLL;
          3'b010:  ctrl.alu_ctrl = ALU_SLT;
          3'b011:  ctrl.alu_ctrl = ALU_SLTU;
          3'b100:  ctrl.alu_ctrl = ALU_XOR;
          3'b101:  ctrl.alu_ctrl = alt ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl.alu_ctrl = ALU_OR;
          default: ctrl.alu_ctrl = ALU_AND;
        endcase
      end
      default: ;
    endcase
  end

  assign imm_src   = ctrl.imm_src;
  assign reg_write = ctrl.reg_write;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [SHAMT_W-1:0] shamt;
  logic               cmp_ctrl;
  logic               cmp_true;

  assign op_a     = ctrl.a_pc  ? pc  : rd1;
  assign op_b     = ctrl.b_imm ? imm : rd2;
  assign shamt    = op_b[SHAMT_W-1:0];
  assign cmp_ctrl = (ctrl.alu_ctrl >= ALU_BLT) && (ctrl.alu_ctrl <= ALU_BGEU);

  // Branch comparators; their outcome doubles as eq and as the result LSB.
  always_comb begin
    cmp_true = 1'b0;
    case (ctrl.alu_ctrl)
      ALU_BLT:  cmp_true = $signed(op_a) <  $signed(op_b);
      ALU_BGE:  cmp_true = $signed(op_a) >= $signed(op_b);
      ALU_BLTU: cmp_true = op_a <  op_b;
      ALU_BGEU: cmp_true = op_a >= op_b;
      default:  cmp_true = 1'b0;
    endcase
  end

  assign eq = cmp_ctrl ? cmp_true : (op_a == op_b);

  always_comb begin
    alu_result = '0;
    case (ctrl.alu_ctrl)
      ALU_ADD:  alu_result = op_a + op_b;
      ALU_SUB:  alu_result = op_a - op_b;
      ALU_AND:  alu_result = op_a & op_b;
      ALU_OR:   alu_result = op_a | op_b;
      ALU_XOR:  alu_result = op_a ^ op_b;
      ALU_SLL:  alu_result = op_a << shamt;
      ALU_SRL:  alu_result = op_a >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(op_a) >>> shamt);
      ALU_SLT:  alu_result = {(WIDTH-1)'(0), $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_result = {(WIDTH-1)'(0), op_a < op_b};
      ALU_PASS: alu_result = op_b;
      ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU:
                alu_result = {(WIDTH-1)'(0), cmp_true};
      default:  alu_result = '0;
    endcase
  end

  // Next-PC select; jumps outrank branches.
  always_comb begin
    pc_src = 2'b00;
    if (ctrl.jump == JMP_JALR) begin
      pc_src = 2'b10;
    end else if (ctrl.jump == JMP_JAL) begin
      pc_src = 2'b01;
    end else if ((ctrl.branch == BR_BEQ || ctrl.branch > BR_BNE) && eq) begin
      pc_src = 2'b01;
    end else if (ctrl.branch == BR_BNE && !eq) begin
      pc_src = 2'b01;
    end
  end

  // Data memory: byte array, addresses wrap within MEM_ABITS.
  logic [7:0]           mem_q [MEM_BYTES];
  logic [MEM_ABITS-1:0] addr0, addr1, addr2, addr3;
  logic [31:0]          mem_word;

  assign addr0    = alu_result[MEM_ABITS-1:0];
  assign addr1    = addr0 + MEM_ABITS'(1);
  assign addr2    = addr0 + MEM_ABITS'(2);
  assign addr3    = addr0 + MEM_ABITS'(3);
  assign mem_word = {mem_q[addr3], mem_q[addr2], mem_q[addr1], mem_q[addr0]};

  always_comb begin
    read_data = '0;
    case (ctrl.mem_mode)
      MEM_LW:  read_data = WIDTH'(mem_word);
      MEM_LH:  read_data = WIDTH'($signed(mem_word[15:0]));
      MEM_LHU: read_data = WIDTH'(mem_word[15:0]);
      MEM_LB:  read_data = WIDTH'($signed(mem_word[7:0]));
      MEM_LBU: read_data = WIDTH'(mem_word[7:0]);
      default: read_data = '0;
    endcase
  end

  // Stores commit at the clock edge, so a same-cycle load sees old data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (ctrl.mem_mode)
        MEM_SW: begin
          mem_q[addr0] <= rd2[7:0];
          mem_q[addr1] <= rd2[15:8];
          mem_q[addr2] <= rd2[23:16];
          mem_q[addr3] <= rd2[31:24];
        end
        MEM_SH: begin
          mem_q[addr0] <= rd2[7:0];
          mem_q[addr1] <= rd2[15:8];
        end
        MEM_SB: mem_q[addr0] <= rd2[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    wb_data = alu_result;
    if (ctrl.wb_link) begin
      wb_data = pc + WIDTH'(4);
    end else if (ctrl.wb_mem) begin
      wb_data = read_data;
    end
  end

endmodule

// File: tb/tb_exec_mem_slice.sv
// Randomized scoreboard bench for exec_mem_slice against an instruction-level reference model.
module tb_exec_mem_slice;

  localparam int unsigned MASK = 32'h0001_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0, rd1 = '0, rd2 = '0, pc = '0, imm = '0;
  logic [2:0]  imm_src;
  logic        reg_write, eq;
  logic [4:0]  rd_addr;
  logic [31:0] alu_result, read_data, wb_data;
  logic [1:0]  pc_src;

  exec_mem_slice dut (
    .clk(clk), .rst(rst), .instr(instr), .rd1(rd1), .rd2(rd2), .pc(pc), .imm(imm),
    .imm_src(imm_src), .reg_write(reg_write), .rd_addr(rd_addr), .alu_result(alu_result),
    .eq(eq), .pc_src(pc_src), .read_data(read_data), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  imm_src;  bit chk_imm;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;      bit chk_alu;
    logic        eq;       bit chk_eq;
    logic [1:0]  pc_src;
    logic [31:0] rdata;
    logic [31:0] wb;       bit chk_wb;
  } exp_t;

  exp_t sb [$];
  logic [7:0] mem_m [int unsigned];
  int checks = 0;
  int failures = 0;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    int unsigned k = a & MASK;
    return mem_m.exists(k) ? mem_m[k] : 8'h00;
  endfunction

  function automatic logic [31:0] alu_fn(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Architectural meaning of each instruction, straight from the ISA rules.
  function automatic exp_t model(input logic [31:0] ins, a1, a2, pcv, immv);
    exp_t e;
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [31:0] w;
    e.name = ""; e.imm_src = 3'd0; e.chk_imm = 1; e.rw = 0; e.rd = ins[11:7];
    e.alu = 0; e.chk_alu = 1; e.eq = 0; e.chk_eq = 1; e.pc_src = 0; e.rdata = 0;
    e.wb = 0; e.chk_wb = 1;
    case (opc)
      7'b0110111: begin e.imm_src = 3; e.rw = 1; e.alu = immv; e.eq = (a1 == immv); end
      7'b0010111: begin e.imm_src = 3; e.rw = 1; e.alu = pcv + immv; e.eq = (pcv == immv); end
      7'b1101111: begin e.imm_src = 4; e.rw = 1; e.chk_alu = 0; e.eq = (a1 == immv); e.pc_src = 1; end
      7'b1100111: begin e.imm_src = 0; e.rw = 1; e.alu = a1 + immv; e.eq = (a1 == immv); e.pc_src = 2; end
      7'b1100011: begin
        e.imm_src = 2;
        case (f3)
          3'd0: begin e.eq = (a1 == a2); e.chk_alu = 0; e.pc_src = e.eq ? 2'd1 : 2'd0; end
          3'd1: begin e.eq = (a1 == a2); e.chk_alu = 0; e.pc_src = e.eq ? 2'd0 : 2'd1; end
          3'd4: e.eq = $signed(a1) <  $signed(a2);
          3'd5: e.eq = $signed(a1) >= $signed(a2);
          3'd6: e.eq = a1 <  a2;
          default: e.eq = a1 >= a2;
        endcase
        if (f3 >= 3'd4) begin e.alu = {31'd0, e.eq}; e.pc_src = e.eq ? 2'd1 : 2'd0; end
      end
      7'b0000011: begin
        e.imm_src = 0; e.rw = 1; e.alu = a1 + immv; e.eq = (a1 == immv);
        w = {rd_byte(e.alu + 3), rd_byte(e.alu + 2), rd_byte(e.alu + 1), rd_byte(e.alu)};
        case (f3)
          3'd0: e.rdata = {{24{w[7]}}, w[7:0]};
          3'd1: e.rdata = {{16{w[15]}}, w[15:0]};
          3'd2: e.rdata = w;
          3'd4: e.rdata = {24'd0, w[7:0]};
          default: e.rdata = {16'd0, w[15:0]};
        endcase
      end
      7'b0100011: begin e.imm_src = 1; e.alu = a1 + immv; e.eq = (a1 == immv); end
      7'b0010011: begin
        e.rw = 1; e.alu = alu_fn(f3, (f3 == 3'd5) && ins[30], a1, immv); e.eq = (a1 == immv);
      end
      7'b0110011: begin
        e.chk_imm = 0; e.rw = 1; e.alu = alu_fn(f3, ins[30], a1, a2); e.eq = (a1 == a2);
      end
      default: begin e.chk_imm = 0; e.chk_alu = 0; e.chk_eq = 0; end
    endcase
    if (opc == 7'b1101111 || opc == 7'b1100111) e.wb = pcv + 32'd4;
    else if (opc == 7'b0000011) e.wb = e.rdata;
    else begin e.wb = e.alu; e.chk_wb = e.chk_alu; end
    return e;
  endfunction

  task automatic issue(input string nm, input logic [31:0] ins, a1, a2, pcv, immv,
                       input logic rs);
    exp_t e;
    int n;
    @(posedge clk); #1;
    instr = ins; rd1 = a1; rd2 = a2; pc = pcv; imm = immv; rst = rs;
    e = model(ins, a1, a2, pcv, immv);
    e.name = nm;
    sb.push_back(e);
    if (!rs && ins[6:0] == 7'b0100011 && ins[14:12] <= 3'd2) begin
      n = (ins[14:12] == 3'd0) ? 1 : (ins[14:12] == 3'd1) ? 2 : 4;
      for (int k = 0; k < n; k++) begin
        logic [31:0] sh;
        sh = a2 >> (8 * k);
        mem_m[(e.alu + 32'(k)) & MASK] = sh[7:0];
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp_v);
    end
  endtask

  // Monitor: compares each issued instruction while its inputs are still applied.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.name, ".reg_write"}, 32'(reg_write), 32'(e.rw));
      chk({e.name, ".rd_addr"}, 32'(rd_addr), 32'(e.rd));
      chk({e.name, ".pc_src"}, 32'(pc_src), 32'(e.pc_src));
      chk({e.name, ".read_data"}, read_data, e.rdata);
      if (e.chk_imm) chk({e.name, ".imm_src"}, 32'(imm_src), 32'(e.imm_src));
      if (e.chk_alu) chk({e.name, ".alu_result"}, alu_result, e.alu);
      if (e.chk_eq)  chk({e.name, ".eq"}, 32'(eq), 32'(e.eq));
      if (e.chk_wb)  chk({e.name, ".wb_data"}, wb_data, e.wb);
    end
  end

  initial begin
    logic [6:0]  unk [5];
    logic [2:0]  ld_f3 [5];
    logic [2:0]  br_f3 [6];
    logic [31:0] ins, a1, a2, pcv, immv;
    int cls;
    unk   = '{7'b0001111, 7'b1110011, 7'b0000000, 7'b1111111, 7'b0101111};
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    issue("reset_nop", 32'h0000_0000, 32'h1234_5678, 32'h9, 32'h0, 32'h0, 1'b1);
    issue("reset_sw_blocked", 32'h0000_2023, 32'h300, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1);
    issue("lw_after_blocked", 32'h0000_2003, 32'h300, 32'h0, 32'h0, 32'h0, 1'b0);
    issue("addi_neg", 32'hFFB0_0093, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFB, 1'b0);
    issue("sw_100", 32'h0000_2023, 32'h100, 32'h80FF_1234, 32'h0, 32'h0, 1'b0);
    issue("lb_100", 32'h0000_0003, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0);
    issue("lbu_100", 32'h0000_4003, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0);
    issue("lh_100", 32'h0000_1003, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0);
    issue("lw_100", 32'h0000_2003, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0);
    issue("lh_103_hi", 32'h0000_1003, 32'h103, 32'h0, 32'h0, 32'h0, 1'b0);
    issue("bne_equal", 32'h0000_1063, 32'd7, 32'd7, 32'h0, 32'h10, 1'b0);
    issue("blt_neg", 32'h0000_4063, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h10, 1'b0);
    issue("jalr", 32'h0000_0067, 32'h200, 32'h0, 32'h40, 32'd4, 1'b0);
    issue("sw_wrap", 32'h0000_2023, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 32'h0, 32'h0, 1'b0);
    issue("lw_wrap", 32'h0000_2003, 32'h0001_FFFE, 32'h0, 32'h0, 32'h0, 1'b0);
    issue("lbu_wrap0", 32'h0000_4003, 32'h0002_0000, 32'h0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      ins = $urandom; a1 = $urandom; a2 = $urandom; pcv = $urandom & 32'hFFFF_FFFC;
      immv = $urandom;
      if ($urandom_range(0, 3) == 0) a2 = a1;
      cls = $urandom_range(0, 9);
      case (cls)
        0: ins[6:0] = 7'b0110111;
        1: ins[6:0] = 7'b0010111;
        2: ins[6:0] = 7'b1101111;
        3: begin ins[6:0] = 7'b1100111; ins[14:12] = 3'd0; end
        4: begin ins[6:0] = 7'b1100011; ins[14:12] = br_f3[$urandom_range(0, 5)]; end
        5, 6: begin
          ins[6:0] = (cls == 5) ? 7'b0000011 : 7'b0100011;
          ins[14:12] = (cls == 5) ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
          a1 = $urandom_range(0, 1) ? 32'h1000 + $urandom_range(0, 15)
                                    : ($urandom & 32'hFFFE_0000) | (32'h1FFF8 + $urandom_range(0, 7));
          immv = $urandom_range(0, 7);
        end
        7: ins[6:0] = 7'b0010011;
        8: ins[6:0] = 7'b0110011;
        default: ins[6:0] = unk[$urandom_range(0, 4)];
      endcase
      issue($sformatf("rnd%0d", i), ins, a1, a2, pcv, immv, $urandom_range(0, 7) == 0);
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
